// File: rtl/riscv_pkg.sv
// Shared RISC-V integer ALU operation encoding.
package riscv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// master: requesters plus the external ALU; slave: the arbiter itself.
interface alu_arbiter_if #(
   parameter int NREQ = 2
);

   logic [NREQ-1:0]                  req_valid;
   logic [NREQ-1:0]                  req_ready;
   logic [NREQ-1:0][31:0]            req_a;
   logic [NREQ-1:0][31:0]            req_b;
   riscv_pkg::alu_op_t [NREQ-1:0]    req_op;
   logic [NREQ-1:0]                  rsp_valid;
   logic [NREQ-1:0]                  rsp_ready;
   logic [31:0]                      rsp_res;
   logic                             busy;
   logic [31:0]                      alu_a;
   logic [31:0]                      alu_b;
   riscv_pkg::alu_op_t               alu_op;
   logic [31:0]                      alu_res;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready, alu_res,
      input  req_ready, rsp_valid, rsp_res, busy, alu_a, alu_b, alu_op
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready, alu_res,
      output req_ready, rsp_valid, rsp_res, busy, alu_a, alu_b, alu_op
   );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Operands are registered onto the ALU, the result is captured one cycle
// later and held until the owning requester accepts it.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no transaction in flight
// EXEC  | operands registered, ALU evaluating
// RESP  | result held, waiting for rsp_ready[gid]
module alu_arbiter #(
   parameter int NREQ = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDW-1:0]       r_ptr;
   logic [IDW-1:0]       r_gid;
   logic [NREQ-1:0]      r_rsp_valid;
   logic [31:0]          r_rsp_res;
   logic [31:0]          r_alu_a;
   logic [31:0]          r_alu_b;
   riscv_pkg::alu_op_t   r_alu_op;

   logic                 w_any;
   logic [IDW-1:0]       w_win;
   logic                 w_handshake;
   logic                 w_accept;
   logic                 w_grant;
   logic [NREQ-1:0]      w_req_ready;
   logic [NREQ-1:0]      w_gid_oh;
   logic                 w_busy;

   // Round-robin search from ptr; walking backwards leaves the closest hit.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         logic [IDW-1:0] idx;
         idx = IDW'((int'(r_ptr) + i) % NREQ);
         if (bus.req_valid[idx]) begin
            w_any = 1'b1;
            w_win = idx;
         end
      end
   end

   // Accept qualification and owner one-hot decode.
   always_comb begin
      w_gid_oh        = '0;
      w_gid_oh[r_gid] = 1'b1;
      w_handshake     = (r_state == RESP) && r_rsp_valid[r_gid] && bus.rsp_ready[r_gid];
      w_accept        = (r_state == IDLE) || w_handshake;
      w_grant         = w_accept && w_any;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; EXEC always completes in one cycle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_grant) w_state_nxt = EXEC;
         EXEC:    w_state_nxt = RESP;
         RESP:    if (w_handshake) w_state_nxt = w_grant ? EXEC : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs: grant strobe to the winner and busy flag.
   always_comb begin
      w_req_ready = '0;
      if (w_grant) w_req_ready[w_win] = 1'b1;
      w_busy = (r_state != IDLE);
   end

   // Grant bookkeeping and ALU operand registers, loaded only on a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_gid    <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= riscv_pkg::ALU_ADD;
      end else if (w_grant) begin
         r_ptr    <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
         r_gid    <= w_win;
         r_alu_a  <= bus.req_a[w_win];
         r_alu_b  <= bus.req_b[w_win];
         r_alu_op <= bus.req_op[w_win];
      end
   end

   // Response capture after EXEC, cleared on the owner's handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= '0;
         r_rsp_res   <= '0;
      end else if (r_state == EXEC) begin
         r_rsp_valid <= w_gid_oh;
         r_rsp_res   <= bus.alu_res;
      end else if (w_handshake) begin
         r_rsp_valid <= '0;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_res   = r_rsp_res;
   assign bus.busy      = w_busy;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_op    = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;
   import riscv_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_arbiter_if #(.NREQ(2)) bus ();

   alu_arbiter #(.NREQ(2)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the external combinational ALU.
   always_comb begin
      bus.alu_res = 32'h0;
      case (bus.alu_op)
         ALU_ADD:  bus.alu_res = bus.alu_a + bus.alu_b;
         ALU_SUB:  bus.alu_res = bus.alu_a - bus.alu_b;
         ALU_SLL:  bus.alu_res = bus.alu_a << bus.alu_b[4:0];
         ALU_SLT:  bus.alu_res = {31'h0, $signed(bus.alu_a) < $signed(bus.alu_b)};
         ALU_SLTU: bus.alu_res = {31'h0, bus.alu_a < bus.alu_b};
         ALU_XOR:  bus.alu_res = bus.alu_a ^ bus.alu_b;
         ALU_SRL:  bus.alu_res = bus.alu_a >> bus.alu_b[4:0];
         ALU_SRA:  bus.alu_res = $signed(bus.alu_a) >>> bus.alu_b[4:0];
         ALU_OR:   bus.alu_res = bus.alu_a | bus.alu_b;
         ALU_AND:  bus.alu_res = bus.alu_a & bus.alu_b;
         default:  bus.alu_res = 32'h0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input int idx, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
      logic [31:0] oh;
      oh = 32'(1) << idx;
      bus.req_valid      = '0;
      bus.req_valid[idx] = 1'b1;
      bus.req_a[idx]     = a;
      bus.req_b[idx]     = b;
      bus.req_op[idx]    = op;
      bus.rsp_ready      = 2'b11;
      #1;
      chk({tag, "_ready"}, 32'(bus.req_ready), oh);
      step();
      bus.req_valid = '0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      step();
      chk({tag, "_rvalid"}, 32'(bus.rsp_valid), oh);
      chk({tag, "_res"}, bus.rsp_res, exp);
      step();
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
      chk({tag, "_rclr"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = {ALU_ADD, ALU_ADD};
      bus.rsp_ready = '0;

      // reset values
      step();
      step();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_res", bus.rsp_res, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_alu_b", bus.alu_b, 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      rst_n = 1'b1;

      // simultaneous requests straight out of reset
      bus.req_a[0] = 32'd10;          bus.req_b[0] = 32'd3;          bus.req_op[0] = ALU_SUB;
      bus.req_a[1] = 32'hF0F0_0000;   bus.req_b[1] = 32'h0F0F_0000;  bus.req_op[1] = ALU_XOR;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      #1;
      chk("sim_first_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 2'b10;
      chk("sim_exec_ready", 32'(bus.req_ready), 32'd0);
      chk("sim_alu_op0", 32'(bus.alu_op), 32'(ALU_SUB));
      step();
      chk("sim_rvalid0", 32'(bus.rsp_valid), 32'd1);
      chk("sim_res0", bus.rsp_res, 32'd7);
      chk("sim_second_ready", 32'(bus.req_ready), 32'd2);
      step();
      bus.req_valid = 2'b00;
      chk("sim_rclr0", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("sim_rvalid1", 32'(bus.rsp_valid), 32'd2);
      chk("sim_res1", bus.rsp_res, 32'hFFFF_0000);
      step();
      chk("sim_idle", 32'(bus.busy), 32'd0);

      // fairness: both valid, 8 operations, pointer back at 0 from before
      bus.req_a[0] = 32'd1;  bus.req_b[0] = 32'd2; bus.req_op[0] = ALU_ADD;
      bus.req_a[1] = 32'd10; bus.req_b[1] = 32'd4; bus.req_op[1] = ALU_SUB;
      bus.req_valid = 2'b11;
      #1;
      chk("fair_ptr0_ready", 32'(bus.req_ready), 32'd1);
      step();
      for (int n = 0; n < 8; n++) begin
         chk("fair_exec_ready", 32'(bus.req_ready), 32'd0);
         step();
         chk("fair_rvalid", 32'(bus.rsp_valid), 32'(1) << (n % 2));
         chk("fair_res", bus.rsp_res, (n % 2 == 0) ? 32'd3 : 32'd6);
         if (n == 7) bus.req_valid = 2'b00;
         #1;
         chk("fair_next_ready", 32'(bus.req_ready), (n == 7) ? 32'd0 : 32'(1) << ((n + 1) % 2));
         step();
      end
      chk("fair_idle", 32'(bus.busy), 32'd0);

      // single request
      do_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, "single");

      // backpressure on requester 1 while requester 0 waits
      bus.req_a[1] = 32'hFFFF_FFF8; bus.req_b[1] = 32'd1; bus.req_op[1] = ALU_SRA;
      bus.req_valid = 2'b10;
      bus.rsp_ready = 2'b01;
      #1;
      chk("bp_ready1", 32'(bus.req_ready), 32'd2);
      step();
      bus.req_valid = 2'b01;
      bus.req_a[0] = 32'd5; bus.req_b[0] = 32'd7; bus.req_op[0] = ALU_ADD;
      chk("bp_exec_ready", 32'(bus.req_ready), 32'd0);
      step();
      for (int c = 0; c < 3; c++) begin
         chk("bp_hold_rvalid", 32'(bus.rsp_valid), 32'd2);
         chk("bp_hold_res", bus.rsp_res, 32'hFFFF_FFFC);
         chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 2'b10;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 2'b00;
      chk("bp_rclr", 32'(bus.rsp_valid), 32'd0);
      chk("bp_alu_a", bus.alu_a, 32'd5);
      step();
      chk("bp_rvalid0", 32'(bus.rsp_valid), 32'd1);
      chk("bp_res0", bus.rsp_res, 32'd12);
      bus.rsp_ready = 2'b11;
      step();
      chk("bp_idle", 32'(bus.busy), 32'd0);

      // shift / compare passthrough
      do_op(0, ALU_SLL,  32'd1,         32'd31, 32'h8000_0000, "sll");
      do_op(1, ALU_SLT,  32'hFFFF_FFFF, 32'd1,  32'd1,         "slt");
      do_op(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,  32'd0,         "sltu");

      // reset while in EXEC
      bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd9; bus.req_op[0] = ALU_SUB;
      bus.req_valid = 2'b01;
      step();
      chk("mid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      #1;
      chk("mid_rvalid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_busy_rst", 32'(bus.busy), 32'd0);
      chk("mid_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      chk("mid_alu_a", bus.alu_a, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("post_rst_rvalid", 32'(bus.rsp_valid), 32'd0);
         chk("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single integer ALU between NREQ independent requesters, such as the execute stage and a multi-cycle address/branch helper. It arbitrates round-robin and registers the granted operands onto the ALU inputs. It then captures the ALU result into a response register that is held until the owning requester accepts it. The block sits between the requesters and the combinational ALU; the ALU itself is instantiated outside and connected through the alu_* ports.

## Interface
- NREQ, default 2: number of requesters, range 2..8.
- IDW: derived as $clog2(NREQ); width of the grant pointer.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ x 32  per-requester operand A (packed array).
- req_b  in  NREQ x 32  per-requester operand B.
- req_op  in  NREQ x alu_op_t  per-requester operation (riscv_pkg).
- rsp_valid  out  NREQ  one-hot; result ready for that requester.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_res  out  32  result; valid only while a rsp_valid bit is high.
- busy  out  1  high whenever state is not IDLE.
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_op  out  alu_op_t  registered operation to the ALU.
- alu_res  in  32  combinational ALU result.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - EXEC: operands registered; ALU is evaluating.
  - RESP: result held and waiting for rsp_ready.
- Arbitration:
  - Round-robin with pointer ptr (IDW bits, reset 0).
  - The winner is the first requester with req_valid set, searching ptr, ptr+1, … NREQ-1, 0, … with wrap-around.
  - On a grant to requester g, ptr <= g+1, wrapping to 0 when g == NREQ-1.
- Accept condition: accept = (state==IDLE) or (state==RESP and rsp_valid[gid] and rsp_ready[gid]).
  - req_ready[winner] = accept and any req_valid; every other req_ready bit is 0.
- On an accepted request:
  - alu_a/alu_b/alu_op <= winner's req_a/req_b/req_op.
  - gid <= winner.
  - State goes to EXEC.
- EXEC: rsp_res <= alu_res, rsp_valid[gid] <= 1, and state goes to RESP. The transition is unconditional.
- RESP:
  - rsp_res and rsp_valid are held stable until the handshake with rsp_ready[gid].
  - On handshake with a new request accepted in the same cycle: state goes to EXEC and rsp_valid clears.
  - On handshake with no request pending: state goes to IDLE and rsp_valid clears.
  - rsp_ready bits of non-owning requesters are ignored.
- Requester rule: req_a, req_b, req_op and req_valid must stay stable while req_valid=1 and req_ready=0. A request may be withdrawn only before it is accepted.
- alu_a/alu_b/alu_op keep their last values outside EXEC; they are not cleared.
- Width rules: operands and result are 32 bits with no extension or truncation in this block. All ALU semantics (shift amount is b[4:0], SLT/SLTU produce 0/1) come from the ALU itself.

## Timing
- Reset values:
  - state=IDLE, ptr=0, gid=0.
  - req_ready=0, rsp_valid=0, rsp_res=0, busy=0.
  - alu_a=0, alu_b=0, alu_op=ADD.
- Latency: a request accepted at edge k produces rsp_valid and rsp_res visible after edge k+1.
- Throughput: one operation every 2 cycles with rsp_ready held high, because RESP handshake and new accept share a cycle.
- req_ready is combinational from req_valid, state, ptr and rsp_ready[gid]. There is no combinational path from req_a, req_b or req_op to any output.
- Simultaneous events: when all requesters are valid in the same cycle, exactly one is granted per accept, in strict rotation.
- Reset asserted mid-operation:
  - Any in-flight operation and held result are discarded.
  - All outputs take their reset values asynchronously.
  - No response is issued after rst_n deasserts.
- Backpressure: while in RESP with rsp_ready[gid]=0, there is no grant and req_ready=0 for all requesters.

## Test plan
- Single request: req 0 sends ADD a=5, b=7, accepted at edge k. Required: rsp_valid=01 and rsp_res=12 after edge k+1; busy=0 after the handshake.
- Simultaneous requests: req 0 sends SUB 10−3 and req 1 sends XOR 0xF0F0_0000^0x0F0F_0000, both valid from reset. Required: req 0 is granted first (result 7), then req 1 (result 0xFFFF_0000); ptr=0 afterwards.
- Fairness: both requesters valid continuously with rsp_ready all ones for 8 operations. Required: grants alternate 0,1,0,1,…, and one result arrives every 2 cycles.
- Backpressure: req 1 sends SRA a=0xFFFF_FFF8, b=1, and rsp_ready[1] is held low for 3 cycles while req 0 is valid. Required: rsp_res stays 0xFFFF_FFFC, req_ready stays 0, and req 0 is accepted only in the cycle rsp_ready[1] rises.
- Reset mid-operation: assert rst_n=0 while in EXEC. Required: rsp_valid=0, busy=0 and alu_op=ADD immediately, with no response after release.
- Shift/compare passthrough, one operation each:
  - SLL 1<<31 must give 0x8000_0000.
  - SLT −1<1 must give 1.
  - SLTU 0xFFFF_FFFF<1 must give 0.
  - All three must land at the correct rsp_valid bit.
